// File: rtl/float_to_fixed_stage_if.sv
// Bus bundle for the float-to-fixed converter: input sample stream,
// output result stream and the per-result flags.
//
// Handshake: a sample moves from producer to consumer on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps
// its payload stable until that edge; ready may depend combinationally on
// the consumer's own state but never on the producer's valid.
interface float_to_fixed_stage_if #(
  parameter int FIXED_W = 22
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        float_in;
  logic               out_valid;
  logic               out_ready;
  logic [FIXED_W-1:0] fixed_out;
  logic               sat_flag;
  logic               nan_flag;

  // Environment side: supplies samples and accepts results.
  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, fixed_out, sat_flag, nan_flag
  );

  // Converter side.
  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, fixed_out, sat_flag, nan_flag
  );
endinterface

// File: rtl/float_to_fixed_stage.sv
// Three-stage IEEE-754 single-precision to signed fixed-point converter.
// S1 classifies and computes the alignment shift, S2 shifts/rounds the
// magnitude, S3 applies sign and saturation into the output registers.
// The whole pipeline advances together (global stall, bubbles kept).
module float_to_fixed_stage #(
  parameter int FIXED_W   = 22,
  parameter int FRAC_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  float_to_fixed_stage_if.slave  bus
);

  // Wide enough for a 24-bit significand shifted left by up to FIXED_W-1.
  localparam int WIDE = 24 + FIXED_W;

  localparam logic [FIXED_W-1:0] MAX_POS = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam logic [FIXED_W-1:0] MIN_NEG = {1'b1, {(FIXED_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  logic advance;

  // Stage 1 registers
  logic              v1;
  logic              s1_sign;
  cls_t              s1_cls;
  logic [23:0]       s1_mant;
  logic signed [9:0] s1_k;

  // Stage 2 registers
  logic               v2;
  logic               s2_sign;
  cls_t               s2_cls;
  logic               s2_big;
  logic [FIXED_W-1:0] s2_mag;

  // Unpacked input fields
  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  assign in_exp  = bus.float_in[30:23];
  assign in_frac = bus.float_in[22:0];

  // Everything moves when the output slot is empty or being drained.
  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  // S1: classify the input and compute the signed alignment shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_cls  <= CLS_ZERO;
      s1_mant <= '0;
      s1_k    <= '0;
    end else if (advance) begin
      v1      <= bus.in_valid;
      s1_sign <= bus.float_in[31];
      s1_mant <= {1'b1, in_frac};
      s1_k    <= 10'({2'b00, in_exp}) - 10'd150 + 10'(FRAC_BITS);
      if (in_exp == 8'hFF)
        s1_cls <= (in_frac != '0) ? CLS_NAN : CLS_INF;
      else if (in_exp == 8'h00)
        s1_cls <= CLS_ZERO;
      else
        s1_cls <= CLS_NORM;
    end
  end

  // S2 combinational shift/round of the magnitude.
  logic [WIDE-1:0] wide_mag;
  logic [9:0]      rsh;
  logic [25:0]     rnd_sum;
  logic            shift_big;

  // Left shift for k >= 0, round-half-away right shift for k < 0.
  always_comb begin
    wide_mag  = '0;
    rsh       = '0;
    rnd_sum   = '0;
    shift_big = 1'b0;
    if (!s1_k[9]) begin
      if ($unsigned(s1_k) >= 10'(FIXED_W))
        shift_big = 1'b1;
      else
        wide_mag = WIDE'(s1_mant) << $unsigned(s1_k);
    end else begin
      rsh = $unsigned(-s1_k);
      // Anything shifted past 25 places is below half an LSB.
      if (rsh <= 10'd25) begin
        rnd_sum  = 26'(s1_mant) + (26'd1 << (rsh - 10'd1));
        wide_mag = WIDE'(rnd_sum >> rsh);
      end
    end
  end

  // S2 registers: magnitude low bits plus "too big even for -2^(W-1)" flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_cls  <= CLS_ZERO;
      s2_big  <= 1'b0;
      s2_mag  <= '0;
    end else if (advance) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_big  <= shift_big | (|wide_mag[WIDE-1:FIXED_W]);
      s2_mag  <= wide_mag[FIXED_W-1:0];
    end
  end

  // S3 combinational sign/saturate.
  logic [FIXED_W-1:0] res_fixed;
  logic               res_sat;
  logic               res_nan;

  // Magnitude exactly 2^(W-1) is legal only as the negative extreme.
  always_comb begin
    res_fixed = '0;
    res_sat   = 1'b0;
    res_nan   = 1'b0;
    case (s2_cls)
      CLS_NAN: res_nan = 1'b1;
      CLS_INF: begin
        res_fixed = s2_sign ? MIN_NEG : MAX_POS;
        res_sat   = 1'b1;
      end
      CLS_NORM: begin
        if (s2_sign && !s2_big && (s2_mag == MIN_NEG)) begin
          res_fixed = MIN_NEG;
        end else if (s2_big || s2_mag[FIXED_W-1]) begin
          res_fixed = s2_sign ? MIN_NEG : MAX_POS;
          res_sat   = 1'b1;
        end else begin
          res_fixed = s2_sign ? (~s2_mag + 1'b1) : s2_mag;
        end
      end
      default: res_fixed = '0;
    endcase
  end

  // S3 output registers; held with their flags while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.fixed_out <= '0;
      bus.sat_flag  <= 1'b0;
      bus.nan_flag  <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= v2;
      bus.fixed_out <= res_fixed;
      bus.sat_flag  <= res_sat;
      bus.nan_flag  <= res_nan;
    end
  end

endmodule

// File: doc/float_to_fixed_stage.md
Name: float_to_fixed_stage

Overview:
Pipelined converter from IEEE-754 single-precision (float_in) to the signed fixed-point angle word consumed by the CORDIC stage chain. It sits directly upstream of the CORDIC pipeline and feeds its fixed-point input. It handles classification, shift/round and saturation in three registered stages. A valid/ready handshake with global stall lets downstream stages apply backpressure.

Parameters:
FIXED_W, 22, total width of signed two's-complement output
FRAC_BITS, 20, fractional bits of output (Q(FIXED_W-FRAC_BITS).FRAC_BITS; default range [-2.0, 2.0))

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  float_in carries a sample this cycle
in_ready  output  1  stage accepts a sample this cycle
float_in  input  32  IEEE-754 single-precision value
out_valid  output  1  fixed_out/flags hold a result
out_ready  input  1  downstream accepts result this cycle
fixed_out  output  FIXED_W  signed fixed-point result
sat_flag  output  1  result was saturated (overflow or ±Inf)
nan_flag  output  1  input was NaN; fixed_out forced to 0

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, fixed_out=0, sat_flag=0, nan_flag=0. Reset asserted mid-stream discards all in-flight samples. No output appears for samples accepted before reset.
- Advance: advance = out_ready | ~out_valid. in_ready = advance (combinational). A transfer in occurs when in_valid & in_ready. A transfer out occurs when out_valid & out_ready.
- Stall: when advance=0, every pipeline register holds. Bubbles are not collapsed (global stall).
- Latency: 3 advancing cycles from input transfer to out_valid. Throughput is 1 sample/cycle when out_ready is held high.
- S1 (unpack/classify): sign s, exp e[7:0], mant m[22:0].
  - e=255, m≠0: NaN class.
  - e=255, m=0: Inf class.
  - e=0: zero/denormal, flushed to zero.
  - Otherwise: normal, with M = {1,m} (24 bits) and shift k = e - 150 + FRAC_BITS, as a signed 10-bit value.
- S2 (shift/round on magnitude):
  - If k ≥ 0: mag = M << k. Overflow is flagged if any bit ≥ FIXED_W-1 would be set. Left shifts of FIXED_W or more always overflow.
  - If k < 0: mag = (M + 2^(-k-1)) >> -k, i.e. round half away from zero.
  - For -k > 25: mag = 0, with no shift-width wraparound.
  - Rounding carry that reaches 2^(FIXED_W-1) is flagged as positive overflow (see S3 for the negative case).
- S3 (sign/saturate, registered to outputs):
  - NaN: fixed_out=0, nan_flag=1, sat_flag=0.
  - Inf or overflow: fixed_out=max positive (2^(FIXED_W-1)-1) if s=0, min negative (-2^(FIXED_W-1)) if s=1; sat_flag=1.
  - Exception: s=1 and mag exactly 2^(FIXED_W-1) is representable, so fixed_out=min negative and sat_flag=0.
  - Zero/denormal (either sign): fixed_out=0, no flags.
  - Otherwise: fixed_out = s ? -mag : mag.
- Flags are per-sample and valid only while out_valid=1. They are held with the data during stall.
- A bubble (in_valid=0 while advancing) propagates as valid=0. Data registers may update freely in bubble slots, but outputs change only on advance.

Test Plan:
- 0x3d8f5c29 (0.07), out_ready=1 -> after 3 cycles fixed_out=0x011EB8 (73400, rounded down from 73400.32); flags 0.
- Back-to-back 0x3f800000 (1.0), 0xBF800000 (-1.0), 0xC0000000 (-2.0), 0x80000000 (-0.0) -> 0x100000, 0x300000, 0x200000 (sat_flag=0), 0x000000 on consecutive cycles.
- 0x40800000 (4.0), 0xFF800000 (-Inf), 0x7fc00000 (NaN) -> 0x1FFFFF sat=1; 0x200000 sat=1; 0x000000 nan=1.
- 0x33000000 (2^-25) and denormal 0x00000001 -> 0 with no flags; 0x35000000 (2^-21, exact half LSB) -> 0x000001 (ties away from zero).
- Stream 6 samples with out_ready low for 4 cycles mid-stream -> in_ready low whenever out_valid=1 and out_ready=0; outputs held; all 6 results in order, none lost or duplicated.
- Assert reset for 1 cycle with 2 samples in flight -> next cycle out_valid=0, fixed_out=0, flags 0; the dropped samples never appear; a new sample 3 cycles later is correct.
